// File: rtl/count_stream_checker.sv
// count_stream_checker
//   Watches the output of an 8-bit up-counter (with active-low reset and load)
//   and checks that each observed value matches the value predicted from the
//   previous observed cycle. It locks onto the stream after one sample, counts
//   mismatches, remembers the first one, and drops lock after LOSS_THRESH
//   consecutive mismatches.
//
// Parameters
//   LOSS_THRESH  consecutive mismatches that drop lock (1..15)
//   ERR_W        width of the saturating error counter
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous active-high reset
//   obs_en           sample enable; stream ignored when low
//   obs_rst_l        observed counter's active-low reset
//   obs_load         observed counter's load strobe
//   obs_load_data    observed counter's load value
//   obs_data         observed counter's registered output
//   locked           prediction valid and checking active
//   mismatch         one-cycle pulse, one cycle after a bad sample
//   err_count        total mismatches, saturating
//   first_err_valid  sticky, first mismatch captured
//   first_err_exp    expected value at the first mismatch
//   first_err_act    observed value at the first mismatch
//   lost             sticky, lock was dropped at least once
module count_stream_checker #(
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             obs_en,
  input  logic             obs_rst_l,
  input  logic             obs_load,
  input  logic [7:0]       obs_load_data,
  input  logic [7:0]       obs_data,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_act,
  output logic             lost
);

  typedef enum logic [1:0] {StUnsync, StLocked, StLost} state_e;

  localparam logic [3:0]       LossThr = 4'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] ErrOne  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [7:0]       r_exp;
  logic [3:0]       r_streak;
  logic             r_locked;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err;
  logic             r_fv;
  logic [7:0]       r_fe;
  logic [7:0]       r_fa;
  logic             r_lost;

  logic [7:0] w_pred;
  logic       w_miss;
  logic [3:0] w_streak_inc;
  logic       w_hit_thresh;
  logic       w_err_sat;

  // Counter reset wins over load.
  assign w_pred       = !obs_rst_l ? 8'h00 : (obs_load ? obs_load_data : obs_data + 8'd1);
  assign w_miss       = obs_en && (r_state == StLocked) && (obs_data != r_exp);
  assign w_streak_inc = r_streak + 4'd1;
  assign w_hit_thresh = (w_streak_inc == LossThr);
  assign w_err_sat    = &r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StUnsync;
      r_exp      <= 8'h00;
      r_streak   <= 4'd0;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= '0;
      r_fv       <= 1'b0;
      r_fe       <= 8'h00;
      r_fa       <= 8'h00;
      r_lost     <= 1'b0;
    end else begin
      r_mismatch <= w_miss;
      // Prediction always tracks the stream, even across mismatches.
      if (obs_en) r_exp <= w_pred;
      if (w_miss) begin
        if (!w_err_sat) r_err <= r_err + ErrOne;
        if (!r_fv) begin
          r_fv <= 1'b1;
          r_fe <= r_exp;
          r_fa <= obs_data;
        end
      end
      if (!obs_en) begin
        r_state  <= StUnsync;
        r_locked <= 1'b0;
        r_streak <= 4'd0;
      end else begin
        case (r_state)
          StUnsync: begin
            r_state  <= StLocked;
            r_locked <= 1'b1;
          end
          StLocked: begin
            if (w_miss) begin
              if (w_hit_thresh) begin
                r_state  <= StLost;
                r_locked <= 1'b0;
                r_lost   <= 1'b1;
                r_streak <= 4'd0;
              end else begin
                r_streak <= w_streak_inc;
              end
            end else begin
              r_streak <= 4'd0;
            end
          end
          StLost: begin
            r_state  <= StUnsync;
            r_locked <= 1'b0;
            r_streak <= 4'd0;
          end
          default: begin
            r_state  <= StUnsync;
            r_locked <= 1'b0;
            r_streak <= 4'd0;
          end
        endcase
      end
    end
  end

  assign locked          = r_locked;
  assign mismatch        = r_mismatch;
  assign err_count       = r_err;
  assign first_err_valid = r_fv;
  assign first_err_exp   = r_fe;
  assign first_err_act   = r_fa;
  assign lost            = r_lost;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker. Each step drives one cycle of
// stimulus, a behavioural model computes the outputs expected after the edge
// and pushes them to a scoreboard queue, and the entry is popped and compared
// once the edge has passed. A second instance with ERR_W=2 shares the
// stimulus to cover counter saturation.
module tb_count_stream_checker;

  logic        clk;
  logic        reset;
  logic        obs_en;
  logic        obs_rst_l;
  logic        obs_load;
  logic [7:0]  obs_load_data;
  logic [7:0]  obs_data;

  logic        locked, mismatch, first_err_valid, lost;
  logic [15:0] err_count;
  logic [7:0]  first_err_exp, first_err_act;

  logic        locked2, mismatch2, first_err_valid2, lost2;
  logic [1:0]  err_count2;
  logic [7:0]  first_err_exp2, first_err_act2;

  count_stream_checker #(.LOSS_THRESH(4), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .obs_en(obs_en), .obs_rst_l(obs_rst_l),
    .obs_load(obs_load), .obs_load_data(obs_load_data), .obs_data(obs_data),
    .locked(locked), .mismatch(mismatch), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act), .lost(lost)
  );

  count_stream_checker #(.LOSS_THRESH(4), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .obs_en(obs_en), .obs_rst_l(obs_rst_l),
    .obs_load(obs_load), .obs_load_data(obs_load_data), .obs_data(obs_data),
    .locked(locked2), .mismatch(mismatch2), .err_count(err_count2),
    .first_err_valid(first_err_valid2), .first_err_exp(first_err_exp2),
    .first_err_act(first_err_act2), .lost(lost2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        mis;
    logic [15:0] err;
    logic [1:0]  err2;
    logic        fv;
    logic [7:0]  fe;
    logic [7:0]  fa;
    logic        lost;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Model state: 0 unsync, 1 locked, 2 lost.
  int         m_st = 0;
  int         m_streak = 0;
  int         m_err = 0;
  int         m_err2 = 0;
  logic [7:0] m_exp = 8'h00;
  logic       m_mis = 1'b0;
  logic       m_fv = 1'b0;
  logic [7:0] m_fe = 8'h00;
  logic [7:0] m_fa = 8'h00;
  logic       m_lost = 1'b0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic model(input logic rst, input logic en, input logic rstl, input logic ld,
                       input logic [7:0] ldd, input logic [7:0] dat);
    m_mis = 1'b0;
    if (rst) begin
      m_st = 0; m_streak = 0; m_err = 0; m_err2 = 0; m_exp = 8'h00;
      m_fv = 1'b0; m_fe = 8'h00; m_fa = 8'h00; m_lost = 1'b0;
    end else if (!en) begin
      m_st = 0;
      m_streak = 0;
    end else begin
      if (m_st == 1) begin
        if (dat != m_exp) begin
          m_mis = 1'b1;
          if (m_err < 65535) m_err++;
          if (m_err2 < 3) m_err2++;
          if (!m_fv) begin
            m_fv = 1'b1; m_fe = m_exp; m_fa = dat;
          end
          m_streak++;
          if (m_streak == 4) begin
            m_st = 2; m_lost = 1'b1; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (m_st == 2) begin
        m_st = 0;
        m_streak = 0;
      end else begin
        m_st = 1;
      end
      if (!rstl) m_exp = 8'h00;
      else if (ld) m_exp = ldd;
      else m_exp = 8'(dat + 8'd1);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic rstl, input logic ld,
                       input logic [7:0] ldd, input logic [7:0] dat);
    exp_t e;
    reset = rst; obs_en = en; obs_rst_l = rstl; obs_load = ld;
    obs_load_data = ldd; obs_data = dat;
    model(rst, en, rstl, ld, ldd, dat);
    e.locked = (m_st == 1); e.mis = m_mis; e.err = 16'(m_err); e.err2 = 2'(m_err2);
    e.fv = m_fv; e.fe = m_fe; e.fa = m_fa; e.lost = m_lost;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("locked", 32'(locked), 32'(e.locked));
    chk("mismatch", 32'(mismatch), 32'(e.mis));
    chk("err_count", 32'(err_count), 32'(e.err));
    chk("err_count_w2", 32'(err_count2), 32'(e.err2));
    chk("first_err_valid", 32'(first_err_valid), 32'(e.fv));
    chk("first_err_exp", 32'(first_err_exp), 32'(e.fe));
    chk("first_err_act", 32'(first_err_act), 32'(e.fa));
    chk("lost", 32'(lost), 32'(e.lost));
  endtask

  task automatic s(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, d);
  endtask

  task automatic sl(input logic [7:0] d, input logic [7:0] ldd);
    drive(1'b0, 1'b1, 1'b1, 1'b1, ldd, d);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h55);
  endtask

  initial begin
    reset = 1'b1; obs_en = 1'b0; obs_rst_l = 1'b1; obs_load = 1'b0;
    obs_load_data = 8'h00; obs_data = 8'h00;
    do_reset();
    do_reset();
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_err", 32'(err_count), 32'd0);

    // Free-run across the 8'hFF -> 8'h00 wrap.
    s(8'hFD);
    chk("lock_after_first", 32'(locked), 32'd1);
    s(8'hFE); s(8'hFF); s(8'h00); s(8'h01); s(8'h02);
    chk("wrap_no_err", 32'(err_count), 32'd0);

    // Loads.
    sl(8'h03, 8'h10);
    sl(8'h10, 8'hA5);
    s(8'hA5);
    s(8'hA6);
    chk("load_no_err", 32'(err_count), 32'd0);

    // Single glitch: expected 8'h21, observed 8'h30.
    sl(8'hA7, 8'h20);
    s(8'h20);
    s(8'h30);
    chk("glitch_mis", 32'(mismatch), 32'd1);
    chk("glitch_exp", 32'(first_err_exp), 32'h21);
    chk("glitch_act", 32'(first_err_act), 32'h30);
    chk("glitch_locked", 32'(locked), 32'd1);
    s(8'h31);
    chk("glitch_follow", 32'(mismatch), 32'd0);
    s(8'h32);

    // Loss of lock after four consecutive mismatches.
    do_reset();
    s(8'h40); s(8'h41);
    s(8'h00); s(8'h00); s(8'h00);
    chk("loss_still_locked", 32'(locked), 32'd1);
    s(8'h00);
    chk("loss_lost", 32'(lost), 32'd1);
    chk("loss_unlocked", 32'(locked), 32'd0);
    chk("loss_err", 32'(err_count), 32'd4);
    chk("loss_first_exp", 32'(first_err_exp), 32'h42);
    s(8'h01);
    chk("lost_to_unsync", 32'(locked), 32'd0);
    s(8'h05);
    chk("relock", 32'(locked), 32'd1);
    s(8'h06);

    // Gap in sampling, then reset-over-load priority.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07);
    chk("gap_unlocked", 32'(locked), 32'd0);
    s(8'h50);
    chk("gap_relock", 32'(locked), 32'd1);
    s(8'h51);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h52);
    s(8'h00);
    chk("rst_over_load", 32'(mismatch), 32'd0);

    // Reset while locked with errors recorded.
    s(8'h09); s(8'h0A);
    do_reset();
    chk("mid_reset_err", 32'(err_count), 32'd0);
    chk("mid_reset_lost", 32'(lost), 32'd0);

    // Five isolated mismatches saturate the 2-bit counter.
    s(8'h60);
    for (int i = 0; i < 5; i++) begin
      s(8'(8'h70 + 8'(i * 16)));
      s(8'(8'h71 + 8'(i * 16)));
    end
    chk("sat_w2", 32'(err_count2), 32'h3);
    chk("sat_w16", 32'(err_count), 32'd5);
    chk("sat_no_loss", 32'(lost), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
